// File: rtl/oled_draw_sequencer.sv
// oled_draw_sequencer: turns pixel/rect/clear requests into SSD1331 command batches
// and sequences them through the OLEDrgb driver's start/cmd_reset handshake.
module oled_draw_sequencer #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int X_MAX          = 95,
  parameter int Y_MAX          = 63
) (
  input  logic         i_clk,
  input  logic         i_n_reset,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic [1:0]   i_req_op,
  input  logic [6:0]   i_x0,
  input  logic [5:0]   i_y0,
  input  logic [6:0]   i_x1,
  input  logic [5:0]   i_y1,
  input  logic [15:0]  i_color,
  output logic         o_start,
  output logic         o_cmd_reset,
  output logic [3:0]   o_num_cmd,
  output logic [119:0] o_cmd_flat,
  input  logic         i_done,
  output logic         o_busy,
  output logic         o_err
);
  typedef enum logic [2:0] {INIT, START, WAIT_DONE, CLR, GAP, IDLE} state_t;
  localparam int CMAX = TIMEOUT_CYCLES > GAP_CYCLES ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [6:0] XM = 7'(X_MAX);
  localparam logic [5:0] YM = 6'(Y_MAX);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic start_q, start_d, cmd_reset_q, cmd_reset_d, err_q, err_d;
  logic [3:0] num_q, num_d;
  logic [119:0] flat_q, flat_d;
  logic pixel, is_clr, legal;
  logic [6:0] ex1;
  logic [5:0] ey1, r6, b6;
  logic [7:0] bx0, by0, bx1, by1, br, bg, bb;
  logic [119:0] batch;
  // a pixel is just a 1x1 rectangle, so it shares the rect encoding and checks
  always_comb begin
    pixel  = i_req_op == 2'b00;
    is_clr = i_req_op == 2'b10;
    ex1    = pixel ? i_x0 : i_x1;
    ey1    = pixel ? i_y0 : i_y1;
    legal  = i_req_op != 2'b11 && i_x0 <= XM && ex1 <= XM && i_y0 <= YM && ey1 <= YM &&
             ex1 >= i_x0 && ey1 >= i_y0;
    r6     = {i_color[15:11], i_color[15]};
    b6     = {i_color[4:0], i_color[4]};
    bx0    = {1'b0, i_x0};
    by0    = {2'b0, i_y0};
    bx1    = {1'b0, ex1};
    by1    = {2'b0, ey1};
    br     = {2'b0, r6};
    bg     = {2'b0, i_color[10:5]};
    bb     = {2'b0, b6};
    batch  = is_clr ? {80'h0, by1, bx1, by0, bx0, 8'h25}
                    : {32'h0, bb, bg, br, bb, bg, br, by1, bx1, by0, bx0, 8'h22};
  end
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start_d     = 1'b0;
    cmd_reset_d = 1'b0;
    err_d       = 1'b0;
    num_d       = num_q;
    flat_d      = flat_q;
    case (state_q)
      INIT: begin
        num_d   = 4'd2;
        flat_d  = {104'h0, 8'h01, 8'h26};
        state_d = START;
      end
      START: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_done || cnt_q == T_LAST) begin
          err_d       = !i_done;
          cmd_reset_d = 1'b1;
          state_d     = CLR;
        end else begin
          start_d = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      CLR: begin
        cnt_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == G_LAST ? IDLE : GAP;
      end
      IDLE: begin
        if (i_req_valid && legal) begin
          flat_d  = batch;
          num_d   = is_clr ? 4'd5 : 4'd11;
          state_d = START;
        end
        err_d = i_req_valid && !legal;
      end
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      cmd_reset_q <= 1'b0;
      err_q       <= 1'b0;
      num_q       <= '0;
      flat_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      cmd_reset_q <= cmd_reset_d;
      err_q       <= err_d;
      num_q       <= num_d;
      flat_q      <= flat_d;
    end
  end
  assign o_req_ready = state_q == IDLE;
  assign o_busy      = state_q != IDLE;
  assign o_start     = start_q;
  assign o_cmd_reset = cmd_reset_q;
  assign o_err       = err_q;
  assign o_num_cmd   = num_q;
  assign o_cmd_flat  = flat_q;
endmodule

// File: tb/tb_oled_draw_sequencer.sv
// tb_oled_draw_sequencer: random and directed requests checked against a byte-level model
// of the SSD1331 batch encoding and the start/done/cmd_reset/gap timing.
module tb_oled_draw_sequencer;
  localparam int GAP = 6;
  localparam int TO  = 64;
  localparam int XMX = 95;
  localparam int YMX = 63;
  logic i_clk = 0, i_n_reset = 0, i_req_valid = 0, i_done = 0;
  logic [1:0] i_req_op = 0;
  logic [6:0] i_x0 = 0, i_x1 = 0;
  logic [5:0] i_y0 = 0, i_y1 = 0;
  logic [15:0] i_color = 0;
  logic o_req_ready, o_start, o_cmd_reset, o_busy, o_err;
  logic [3:0] o_num_cmd;
  logic [119:0] o_cmd_flat;
  int n_cmp = 0, n_bad = 0;

  oled_draw_sequencer #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .X_MAX(XMX), .Y_MAX(YMX)) dut (
    .i_clk(i_clk), .i_n_reset(i_n_reset), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op(i_req_op), .i_x0(i_x0), .i_y0(i_y0), .i_x1(i_x1), .i_y1(i_y1), .i_color(i_color),
    .o_start(o_start), .o_cmd_reset(o_cmd_reset), .o_num_cmd(o_num_cmd), .o_cmd_flat(o_cmd_flat),
    .i_done(i_done), .o_busy(o_busy), .o_err(o_err));

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [119:0] got, input logic [119:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int op, input int x0, input int y0, input int x1, input int y1,
                                input int col, output bit legal, output logic [3:0] n,
                                output logic [119:0] f);
    int b[15];
    int ex1, ey1, r, g, bl;
    ex1 = op == 0 ? x0 : x1;
    ey1 = op == 0 ? y0 : y1;
    legal = op != 3 && x0 <= XMX && ex1 <= XMX && y0 <= YMX && ey1 <= YMX && ex1 >= x0 && ey1 >= y0;
    r  = (col / 2048) % 32;
    g  = (col / 32) % 64;
    bl = col % 32;
    r  = r * 2 + r / 16;
    bl = bl * 2 + bl / 16;
    foreach (b[k]) b[k] = 0;
    b[1] = x0; b[2] = y0; b[3] = ex1; b[4] = ey1;
    if (op == 2) begin
      b[0] = 'h25;
      n = 4'd5;
    end else begin
      b[0] = 'h22;
      b[5] = r; b[6] = g; b[7] = bl; b[8] = r; b[9] = g; b[10] = bl;
      n = 4'd11;
    end
    f = '0;
    for (int k = 0; k < 15; k++) f[8*k +: 8] = 8'(b[k]);
  endfunction

  // mode 0: done after a random delay, 1: done already high on entry, 2: no done (timeout)
  task automatic tail(input int mode);
    int cyc = 1;
    int n = 0;
    if (mode == 0) begin
      int k = $urandom_range(0, 20);
      repeat (k) begin @(posedge i_clk); #1; end
      check("start_hold", 120'(o_start), 120'(1));
      i_done = 1;
      @(posedge i_clk); #1;
      i_done = 0;
    end else if (mode == 1) begin
      @(posedge i_clk); #1;
      i_done = 0;
    end else begin
      do begin
        @(posedge i_clk); #1;
        if (!o_cmd_reset) cyc++;
        n++;
      end while (!o_cmd_reset && n < 200);
      check("timeout_cycles", 120'(cyc), 120'(TO));
    end
    check("clr_cmd_reset", 120'(o_cmd_reset), 120'(1));
    check("clr_start", 120'(o_start), 120'(0));
    check("clr_err", 120'(o_err), 120'(mode == 2));
    @(posedge i_clk); #1;
    check("cmd_reset_pulse", 120'(o_cmd_reset), 120'(0));
    check("err_pulse", 120'(o_err), 120'(0));
    n = 1;
    while (!o_req_ready && n < 200) begin @(posedge i_clk); #1; n++; end
    check("gap_len", 120'(n), 120'(GAP + 1));
  endtask

  task automatic run_req(input int op, input int x0, input int y0, input int x1, input int y1,
                         input int col, input int mode);
    bit legal;
    logic [3:0] en;
    logic [119:0] ef;
    int n = 0;
    model(op, x0, y0, x1, y1, col, legal, en, ef);
    while (!o_req_ready && n < 200) begin @(posedge i_clk); #1; n++; end
    check("ready_idle", 120'(o_req_ready), 120'(1));
    check("busy_idle", 120'(o_busy), 120'(0));
    i_req_op = 2'(op); i_x0 = 7'(x0); i_y0 = 6'(y0); i_x1 = 7'(x1); i_y1 = 6'(y1);
    i_color = 16'(col); i_req_valid = 1;
    @(posedge i_clk); #1;
    i_req_valid = 0;
    i_x0 = 7'($urandom); i_y0 = 6'($urandom); i_x1 = 7'($urandom); i_y1 = 6'($urandom);
    i_color = 16'($urandom); i_req_op = 2'($urandom);
    if (!legal) begin
      check("rej_err", 120'(o_err), 120'(1));
      check("rej_ready", 120'(o_req_ready), 120'(1));
      check("rej_start", 120'(o_start), 120'(0));
      @(posedge i_clk); #1;
      check("rej_err_pulse", 120'(o_err), 120'(0));
      check("rej_start2", 120'(o_start), 120'(0));
      return;
    end
    check("acc_err", 120'(o_err), 120'(0));
    check("acc_start_lat", 120'(o_start), 120'(0));
    check("acc_ready", 120'(o_req_ready), 120'(0));
    if (mode == 1) i_done = 1;
    @(posedge i_clk); #1;
    check("start_rise", 120'(o_start), 120'(1));
    check("num_cmd", 120'(o_num_cmd), 120'(en));
    check("cmd_flat", o_cmd_flat, ef);
    tail(mode);
  endtask

  task automatic init_check();
    @(posedge i_clk); #1;
    check("init_num", 120'(o_num_cmd), 120'(2));
    check("init_flat", o_cmd_flat, 120'h0126);
    check("init_start0", 120'(o_start), 120'(0));
    check("init_busy", 120'(o_busy), 120'(1));
    @(posedge i_clk); #1;
    check("init_start", 120'(o_start), 120'(1));
    tail(0);
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_ready", 120'(o_req_ready), 120'(0));
    check("rst_start", 120'(o_start), 120'(0));
    check("rst_cmd_reset", 120'(o_cmd_reset), 120'(0));
    check("rst_num", 120'(o_num_cmd), 120'(0));
    check("rst_flat", o_cmd_flat, 120'(0));
    check("rst_busy", 120'(o_busy), 120'(1));
    check("rst_err", 120'(o_err), 120'(0));
    @(negedge i_clk) i_n_reset = 1;
    init_check();
    run_req(0, 10, 5, 0, 0, 'hF800, 0);
    run_req(2, 0, 0, 95, 63, 'h1234, 0);
    run_req(1, 20, 3, 10, 9, 'hFFFF, 0);
    run_req(0, 96, 3, 96, 3, 'h07E0, 0);
    run_req(1, 0, 0, 95, 63, 'h07FF, 1);
    run_req(1, 5, 5, 5, 5, 'h001F, 1);
    run_req(3, 1, 1, 2, 2, 'h0, 0);
    run_req(1, 2, 7, 40, 20, 'hABCD, 2);
    for (int i = 0; i < 40; i++) begin
      int op = $urandom_range(0, 3);
      int x0 = $urandom_range(0, 100), y0 = $urandom_range(0, 66);
      int x1 = $urandom_range(0, 100), y1 = $urandom_range(0, 66);
      if (op == 0) begin x1 = $urandom_range(0, XMX); y1 = $urandom_range(0, YMX); end
      run_req(op, x0, y0, x1, y1, int'($urandom_range(0, 65535)), $urandom_range(0, 1));
    end
    // reset during a rect batch's WAIT_DONE
    run_req(0, 1, 1, 0, 0, 'h0, 0);
    i_req_op = 2'b01; i_x0 = 7'd3; i_y0 = 6'd4; i_x1 = 7'd30; i_y1 = 6'd40; i_color = 16'h5A5A;
    i_req_valid = 1;
    @(posedge i_clk); #1;
    i_req_valid = 0;
    @(posedge i_clk); #1;
    check("mid_start", 120'(o_start), 120'(1));
    repeat (3) @(posedge i_clk);
    #2 i_n_reset = 0;
    #1;
    check("mid_rst_start", 120'(o_start), 120'(0));
    check("mid_rst_flat", o_cmd_flat, 120'(0));
    check("mid_rst_num", 120'(o_num_cmd), 120'(0));
    check("mid_rst_ready", 120'(o_req_ready), 120'(0));
    check("mid_rst_busy", 120'(o_busy), 120'(1));
    @(negedge i_clk) i_n_reset = 1;
    init_check();
    run_req(2, 10, 10, 20, 20, 'h0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/oled_draw_sequencer.md
Name: oled_draw_sequencer

Overview:
Front-end controller for the OLEDrgb SPI command driver. Accepts pixel, rectangle and clear-window requests over a valid/ready port and translates each into an SSD1331 command batch of at most 15 bytes. Drives the driver's start / cmd_reset / num_cmd / cmd-byte interface and sequences one batch per request, including the mandatory fill-enable batch after reset. Sits between the dot-painter logic (or PS AXI glue) and the OLEDrgb driver.

Parameters:
GAP_CYCLES, 16, idle cycles inserted after each cmd_reset before the next batch may start (min 1)
TIMEOUT_CYCLES, 1048576, max cycles to wait for i_done before aborting the batch
X_MAX, 95, largest legal column
Y_MAX, 63, largest legal row

Ports:
i_clk  in  1  system clock
i_n_reset  in  1  asynchronous active-low reset
i_req_valid  in  1  request valid
o_req_ready  out  1  request accepted when valid&ready
i_req_op  in  2  00 pixel, 01 filled rect, 10 clear window, 11 reserved
i_x0  in  7  start column
i_y0  in  6  start row
i_x1  in  7  end column (ignored for pixel)
i_y1  in  6  end row (ignored for pixel)
i_color  in  16  RGB565 colour (ignored for clear)
o_start  out  1  to driver i_start, held high for the whole batch
o_cmd_reset  out  1  to driver i_cmd_reset, one-cycle pulse
o_num_cmd  out  4  to driver i_num_cmd
o_cmd_flat  out  120  byte k at [8k+7:8k] drives driver i_cmd_(k+1)
i_done  in  1  from driver o_done
o_busy  out  1  high in any state except IDLE
o_err  out  1  one-cycle pulse: request rejected or driver timeout

Behaviour:
- Reset values: o_req_ready=0, o_start=0, o_cmd_reset=0, o_num_cmd=0, o_cmd_flat=0, o_busy=1, o_err=0. FSM enters INIT.
- States: INIT, START, WAIT_DONE, CLR, GAP, IDLE.
- INIT: load fill-enable batch: num_cmd=2, bytes 0x26,0x01. Next cycle goes to START.
- IDLE: o_req_ready=1, o_busy=0. On valid&ready the request is registered.
  - Legal request: build the batch into o_cmd_flat/o_num_cmd, then go to START the next cycle.
  - Illegal request: o_err=1 for one cycle, nothing is sent, and the FSM stays in IDLE.
  - A request is illegal when op=11, or x0/x1>X_MAX, or y0/y1>Y_MAX, or (op≠pixel and (x1<x0 or y1<y0)).
- Batch encoding. Colour conversion: R6={R5,R5[4]}, G6=G6, B6={B5,B5[4]}.
  - pixel: treated as rect with x1=x0, y1=y0.
  - rect: num_cmd=11. Bytes: 0x22, x0, y0, x1, y1, then R6, G6, B6 as the outline colour, then R6, G6, B6 as the fill colour. Each coordinate/colour byte is zero-extended to 8 bits.
  - clear: num_cmd=5. Bytes: 0x25, x0, y0, x1, y1.
  - All unused bytes are 0x00.
- START: o_start=1. The FSM enters WAIT_DONE on the same edge; o_start stays high through WAIT_DONE.
- WAIT_DONE: o_start=1; the timeout counter increments each cycle.
  - i_done=1: go to CLR.
  - Counter reaches TIMEOUT_CYCLES-1 with no done: o_err pulses and the FSM goes to CLR.
- CLR: exactly one cycle with o_cmd_reset=1 and o_start=0, then GAP. o_cmd_flat/o_num_cmd hold their values until the next batch loads.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- o_req_ready is high only in IDLE. Requests that arrive during a batch are back-pressured and never dropped.
- i_done is ignored outside WAIT_DONE.
- If i_done is already high on entry to WAIT_DONE, the FSM advances on the first WAIT_DONE cycle.
- Async reset asserted mid-batch: all outputs return to reset values immediately. The INIT fill-enable batch is replayed after release, and any pending request is lost.
- Request-to-o_start latency from IDLE: 2 cycles (accept edge, then START).

Test Plan:
- Release reset with i_done pulsing 20 cycles after each o_start → first batch is num_cmd=2, bytes 0x26,0x01; one o_cmd_reset pulse; o_req_ready rises GAP_CYCLES later.
- Pixel request x0=10, y0=5, colour 0xF800 → num_cmd=11; bytes 0x22,0x0A,0x05,0x0A,0x05,0x3F,0x00,0x00,0x3F,0x00,0x00; o_start high 2 cycles after accept until done.
- Clear request (0,0)-(95,63) → num_cmd=5; bytes 0x25,0x00,0x00,0x5F,0x3F; bytes 5..14 are zero.
- Rect request with x0=20, x1=10, and separately a request with x0=96 → each gives one o_err pulse, o_start never rises, o_req_ready stays 1.
- Hold i_done low (TIMEOUT_CYCLES=64 in the bench) → o_err pulses after 64 WAIT_DONE cycles, then o_cmd_reset pulses and the FSM returns to IDLE.
- Assert i_n_reset low during WAIT_DONE of a rect batch → o_start drops at once; after release the fill-enable batch is sent again before o_req_ready rises.
